// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART TX definitions: transmitter FSM state encoding and the
// 100 MHz / 9600 baud bit period used by the transmitter, receiver and benches.
package uart_tx_fifo_pkg;

   localparam int UART_CLKS_PER_BIT_100M_9600 = 10417;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with first-word-fall-through head and registered level/full.
// A push while full is dropped even if a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_reg == CNT_W'(DEPTH));
   assign empty    = (count_reg == '0);
   assign level    = count_reg;
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (rst_n && push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes pushed into a FIFO leave on tx as LSB-first 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int  CLKS_PER_BIT = UART_CLKS_PER_BIT_100M_9600,
   parameter int  FIFO_DEPTH   = 8,
   localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   output logic             full,
   output logic [CNT_W-1:0] level,
   output logic             busy,
   output logic             overflow,
   output logic             tx
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   state_t            state_reg, state_next;
   logic [BAUD_W-1:0] baud_reg, baud_next;
   logic [2:0]        bit_reg, bit_next;
   logic [7:0]        shift_reg, shift_next;
   logic              tx_reg, tx_next;
   logic              busy_reg;
   logic              overflow_reg;
   logic              baud_wrap;
   logic              fifo_pop;
   logic              fifo_empty;
   logic [7:0]        fifo_head;
`ifdef UART_TX_PARITY_EN
   logic              parity_reg, parity_next;
`endif

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (full),
      .empty     (fifo_empty),
      .level     (level)
   );

   assign baud_wrap = (baud_reg == BAUD_LAST);

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      fifo_pop   = 1'b0;
      tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_reg;
`endif
      if (state_reg != ST_IDLE) begin
         baud_next = baud_wrap ? '0 : baud_reg + BAUD_W'(1);
      end
      case (state_reg)
         ST_IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_next = fifo_head;
               baud_next  = '0;
               state_next = ST_START;
`ifdef UART_TX_PARITY_EN
               parity_next = ^fifo_head;
`endif
            end
         end
         ST_START: begin
            tx_next = 1'b0;
            if (baud_wrap) begin
               bit_next   = '0;
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_next = shift_reg[0];
            if (baud_wrap) begin
               shift_next = {1'b0, shift_reg[7:1]};
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            tx_next = parity_reg;
            if (baud_wrap) state_next = ST_STOP;
         end
`endif
         ST_STOP: begin
            tx_next = 1'b1;
            // Chain straight into the next frame so a backlog leaves no idle gap.
            if (baud_wrap) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  shift_next = fifo_head;
                  state_next = ST_START;
`ifdef UART_TX_PARITY_EN
                  parity_next = ^fifo_head;
`endif
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

   // tx and busy are registered from the current state, so the line lags the FSM by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         baud_reg     <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         baud_reg     <= baud_next;
         bit_reg      <= bit_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
         busy_reg     <= (state_reg != ST_IDLE) || !fifo_empty;
         overflow_reg <= overflow_reg || (wr_en && full);
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) parity_reg <= 1'b0;
      else        parity_reg <= parity_next;
   end
`endif

   assign tx       = tx_reg;
   assign busy     = busy_reg;
   assign overflow = overflow_reg;

endmodule
